sound_arbiter: RTL and testbench
================================

// Module: sound_arbiter
// PURPOSE
//  Scheduler that shares the single piezo tone generator among vehicle sound sources.
//  Sources: horn, turn-signal click, warning chime, reverse melody, engine hum.
//  Picks one owner per cycle by fixed priority and times the one-shot click and chime.
//  Drives period/duty/restart for the downstream square-wave tone generator.
// PARAMETERS
//  CLICK_CYC   150_000     click length in clk cycles (3 ms at 50 MHz)
//  CHIME_ON    5_000_000   chime beep length, cycles
//  CHIME_OFF   5_000_000   chime silent gap, cycles
//  CHIME_REPS  3           beeps per chime event (1..15)
//  HORN_HALF   62_500      horn half-period (400 Hz); TICK_HALF 12_500, TOCK_HALF 15_625, CHIME_HALF 28_409
// PORTS
//  clk            in   1   50 MHz system clock
//  rst_n          in   1   asynchronous active-low reset
//  horn_req       in   1   level; horn pressed
//  click_evt      in   1   1-cycle pulse per turn-lamp edge
//  click_hi       in   1   sampled with click_evt: 1=tick, 0=tock
//  chime_evt      in   1   1-cycle pulse; start warning chime
//  melody_req     in   1   level; reverse melody running
//  melody_half    in   20  melody half-period; 0 = rest
//  engine_req     in   1   level; engine on
//  engine_half    in   20  engine half-period from RPM map
//  grant          out  5   one-hot owner {horn,click,chime,melody,engine}; 0 = idle
//  tone_half      out  20  half-period to tone gen; 0 = silence
//  tone_duty      out  2   high-time shift: 0=50%,1=25%,2=12.5%,3=6.25%
//  tone_restart   out  1   1-cycle pulse; tone gen clears its phase counter
//  click_drop     out  1   1-cycle pulse; pending click overwritten
//  chime_busy     out  1   chime pending or in progress
// BEHAVIOUR
//  Reset (async): all outputs 0, pending flags clear, timers 0, state IDLE.
//  States: IDLE, HORN, CLICK, CHIME_ON, CHIME_GAP, MELODY, ENGINE; all outputs registered.
//  Priority: horn > click > chime > melody > engine.
//  Decision made each cycle from current inputs/pending flags; outputs take effect next cycle.
//  click_evt sets click_pend and latches click_hi.
//  - A click_evt while click_pend=1 and not yet served: overwrite click_hi, pulse click_drop.
//  chime_evt sets chime_pend with remaining reps = CHIME_REPS.
//  - Ignored while chime_busy=1.
//  HORN: tone_half=HORN_HALF, duty 1. Preempts any state in 1 cycle.
//  - An in-progress click is aborted and discarded.
//  - An in-progress chime freezes its phase timer and rep count, resuming where it left off.
//  CLICK: timer loads CLICK_CYC-1 on entry; state lasts exactly CLICK_CYC cycles.
//  - tone_half=TICK_HALF if latched hi else TOCK_HALF; duty 2. Clears click_pend on entry.
//  - Preempts chime (frozen, as above), melody and engine.
//  - click_evt in the final click cycle: stay in CLICK, reload timer, pulse tone_restart.
//  CHIME_ON: CHIME_ON cycles, tone_half=CHIME_HALF, duty 1.
//  CHIME_GAP: CHIME_OFF cycles, tone_half=0, grant stays chime.
//  - Rep count decrements at the end of each gap.
//  - After the last gap, chime_busy drops and arbitration resumes.
//  MELODY: tone_half=melody_half (registered, 1-cycle latency), duty 2.
//  ENGINE: tone_half=engine_half (registered), duty 3.
//  Level sources leave their state 1 cycle after the req drops; then re-arbitrate.
//  tone_restart pulses on every grant change and on every CHIME_ON/CHIME_GAP transition.
//  - No pulse while melody_half or engine_half changes within the same owner.
//  Simultaneous click_evt and chime_evt: both latched; click served first, then chime.
//  Timers are 24-bit down-counters; no wrap. A parameter value of 0 is illegal.
//  rst_n asserted mid-sequence: immediate abort; pending events are lost.
// TESTING  (CLICK_CYC=10, CHIME_ON=20, CHIME_OFF=10, CHIME_REPS=2)
//  1 engine_req=1, engine_half=5000 -> cycle+1 grant=00001, tone_half=5000, duty=3, restart pulse.
//  2 click_evt(hi=1) during engine -> grant=01000 for exactly 10 cycles, tone_half=12500, then engine.
//  3 chime_evt alone -> ON 20 / GAP 10 / ON 20 / GAP 10 (tone_half 28409/0), 4 restart pulses, chime_busy 60 cycles.
//  4 horn_req rises at chime ON cycle 8 and holds 15 cycles -> grant=10000.
//    On release, chime resumes with 12 ON cycles left; total chime_busy = 75 cycles.
//  5 two click_evt 3 cycles apart while horn held -> click_drop pulses once.
//    On horn release: one 10-cycle click using the second click_hi.
//  6 rst_n low during CLICK -> all outputs 0 asynchronously; after release, engine re-granted next cycle.

Source files
------------

// File: rtl/sound_arbiter.sv
// sound_arbiter: shares one piezo tone generator among horn, turn click,
// warning chime, reverse melody and engine hum. Fixed priority
// horn > click > chime > melody > engine; the one-shot click and the
// multi-beep chime are timed here. All outputs are registered.
//
// Handshake: there is no backpressure. Requests are levels (horn, melody,
// engine) or 1-cycle event pulses (click, chime); every output is valid on
// the cycle after the inputs that caused it were sampled.
module sound_arbiter #(
  parameter int CLICK_CYC  = 150_000,
  parameter int CHIME_ON   = 5_000_000,
  parameter int CHIME_OFF  = 5_000_000,
  parameter int CHIME_REPS = 3,
  parameter int HORN_HALF  = 62_500,
  parameter int TICK_HALF  = 12_500,
  parameter int TOCK_HALF  = 15_625,
  parameter int CHIME_HALF = 28_409
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        horn_req_i,
  input  logic        click_evt_i,
  input  logic        click_hi_i,
  input  logic        chime_evt_i,
  input  logic        melody_req_i,
  input  logic [19:0] melody_half_i,
  input  logic        engine_req_i,
  input  logic [19:0] engine_half_i,
  output logic [4:0]  grant_o,
  output logic [19:0] tone_half_o,
  output logic [1:0]  tone_duty_o,
  output logic        tone_restart_o,
  output logic        click_drop_o,
  output logic        chime_busy_o,
  output logic [2:0]  dbg_state_o
);

  localparam logic [23:0] CLICK_LD = 24'(CLICK_CYC - 1);
  localparam logic [23:0] ON_LD    = 24'(CHIME_ON - 1);
  localparam logic [23:0] OFF_LD   = 24'(CHIME_OFF - 1);
  localparam logic [3:0]  REPS_LD  = 4'(CHIME_REPS);
  localparam logic [19:0] HORN_H   = 20'(HORN_HALF);
  localparam logic [19:0] TICK_H   = 20'(TICK_HALF);
  localparam logic [19:0] TOCK_H   = 20'(TOCK_HALF);
  localparam logic [19:0] CHIME_H  = 20'(CHIME_HALF);

  typedef enum logic [2:0] {
    S_IDLE, S_HORN, S_CLICK, S_CHIME_ON, S_CHIME_GAP, S_MELODY, S_ENGINE
  } state_t;

  state_t      state_q, state_d;
  logic        click_pend_q, click_pend_d;
  logic        click_hi_q, click_hi_d;     // hi/lo of the click waiting to be served
  logic        click_tone_q, click_tone_d; // hi/lo of the click being played
  logic [23:0] click_tmr_q, click_tmr_d;
  logic        ch_busy_q, ch_busy_d;
  logic        ch_gap_q, ch_gap_d;
  logic [23:0] ch_tmr_q, ch_tmr_d;
  logic [3:0]  ch_reps_q, ch_reps_d;
  logic [4:0]  grant_q, grant_d;
  logic [19:0] half_q, half_d;
  logic [1:0]  duty_q, duty_d;
  logic        restart_q, restart_d;
  logic        drop_q, drop_d;
  logic        click_run, click_load;

  // Chime progress: the phase timer only runs while the chime owns the
  // generator, so a preempted chime stays frozen and resumes in place.
  always_comb begin
    ch_busy_d = ch_busy_q;
    ch_gap_d  = ch_gap_q;
    ch_tmr_d  = ch_tmr_q;
    ch_reps_d = ch_reps_q;
    if (state_q == S_CHIME_ON || state_q == S_CHIME_GAP) begin
      if (ch_tmr_q == 24'd0) begin
        if (!ch_gap_q) begin
          ch_gap_d = 1'b1;
          ch_tmr_d = OFF_LD;
        end else if (ch_reps_q <= 4'd1) begin
          ch_busy_d = 1'b0;
          ch_gap_d  = 1'b0;
          ch_reps_d = 4'd0;
        end else begin
          ch_reps_d = ch_reps_q - 4'd1;
          ch_gap_d  = 1'b0;
          ch_tmr_d  = ON_LD;
        end
      end else begin
        ch_tmr_d = ch_tmr_q - 24'd1;
      end
    end else if (chime_evt_i && !ch_busy_q) begin
      ch_busy_d = 1'b1;
      ch_gap_d  = 1'b0;
      ch_tmr_d  = ON_LD;
      ch_reps_d = REPS_LD;
    end
  end

  // Arbitration, click bookkeeping and next registered outputs.
  always_comb begin
    state_d    = S_IDLE;
    click_load = 1'b0;
    click_run  = (state_q == S_CLICK) && (click_tmr_q != 24'd0);
    if (horn_req_i)                        state_d = S_HORN;
    else if (click_run)                    state_d = S_CLICK;
    else if (click_pend_q || click_evt_i) begin
      state_d    = S_CLICK;
      click_load = 1'b1;
    end
    else if (ch_busy_d)                    state_d = ch_gap_d ? S_CHIME_GAP : S_CHIME_ON;
    else if (melody_req_i)                 state_d = S_MELODY;
    else if (engine_req_i)                 state_d = S_ENGINE;

    click_hi_d   = click_evt_i ? click_hi_i : click_hi_q;
    click_pend_d = (click_pend_q | click_evt_i) & ~click_load;
    click_tone_d = click_load ? click_hi_d : click_tone_q;
    drop_d       = click_evt_i & click_pend_q;
    if (click_load)                                  click_tmr_d = CLICK_LD;
    else if (state_d == S_CLICK && click_tmr_q != 0) click_tmr_d = click_tmr_q - 24'd1;
    else                                             click_tmr_d = click_tmr_q;

    restart_d = (state_d != state_q) | click_load;
    grant_d   = 5'b00000;
    half_d    = 20'd0;
    duty_d    = 2'd0;
    case (state_d)
      S_HORN:      begin grant_d = 5'b10000; half_d = HORN_H;  duty_d = 2'd1; end
      S_CLICK:     begin grant_d = 5'b01000; half_d = click_tone_d ? TICK_H : TOCK_H; duty_d = 2'd2; end
      S_CHIME_ON:  begin grant_d = 5'b00100; half_d = CHIME_H; duty_d = 2'd1; end
      S_CHIME_GAP: begin grant_d = 5'b00100; half_d = 20'd0;   duty_d = 2'd1; end
      S_MELODY:    begin grant_d = 5'b00010; half_d = melody_half_i; duty_d = 2'd2; end
      S_ENGINE:    begin grant_d = 5'b00001; half_d = engine_half_i; duty_d = 2'd3; end
      default:     begin grant_d = 5'b00000; half_d = 20'd0;   duty_d = 2'd0; end
    endcase
  end

  // State, timers, pending flags and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      click_pend_q <= 1'b0;
      click_hi_q   <= 1'b0;
      click_tone_q <= 1'b0;
      click_tmr_q  <= 24'd0;
      ch_busy_q    <= 1'b0;
      ch_gap_q     <= 1'b0;
      ch_tmr_q     <= 24'd0;
      ch_reps_q    <= 4'd0;
      grant_q      <= 5'b00000;
      half_q       <= 20'd0;
      duty_q       <= 2'd0;
      restart_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      click_pend_q <= click_pend_d;
      click_hi_q   <= click_hi_d;
      click_tone_q <= click_tone_d;
      click_tmr_q  <= click_tmr_d;
      ch_busy_q    <= ch_busy_d;
      ch_gap_q     <= ch_gap_d;
      ch_tmr_q     <= ch_tmr_d;
      ch_reps_q    <= ch_reps_d;
      grant_q      <= grant_d;
      half_q       <= half_d;
      duty_q       <= duty_d;
      restart_q    <= restart_d;
      drop_q       <= drop_d;
    end
  end

  assign grant_o        = grant_q;
  assign tone_half_o    = half_q;
  assign tone_duty_o    = duty_q;
  assign tone_restart_o = restart_q;
  assign click_drop_o   = drop_q;
  assign chime_busy_o   = ch_busy_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Bench for sound_arbiter: directed scenarios plus random traffic, compared
// cycle by cycle against a segment/count based model of the arbiter.
module tb_sound_arbiter;

  localparam int CLICK_CYC  = 10;
  localparam int CHIME_ON   = 20;
  localparam int CHIME_OFF  = 10;
  localparam int CHIME_REPS = 2;
  localparam int HORN_HALF  = 62_500;
  localparam int TICK_HALF  = 12_500;
  localparam int TOCK_HALF  = 15_625;
  localparam int CHIME_HALF = 28_409;

  localparam int OWN_IDLE = 0, OWN_HORN = 1, OWN_CLICK = 2, OWN_CHIME = 3,
                 OWN_MELODY = 4, OWN_ENGINE = 5;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        horn_req_i = 1'b0, click_evt_i = 1'b0, click_hi_i = 1'b0, chime_evt_i = 1'b0;
  logic        melody_req_i = 1'b0, engine_req_i = 1'b0;
  logic [19:0] melody_half_i = '0, engine_half_i = '0;
  logic [4:0]  grant_o;
  logic [19:0] tone_half_o;
  logic [1:0]  tone_duty_o;
  logic        tone_restart_o, click_drop_o, chime_busy_o;
  logic [2:0]  dbg_state_o;

  sound_arbiter #(
    .CLICK_CYC(CLICK_CYC), .CHIME_ON(CHIME_ON), .CHIME_OFF(CHIME_OFF),
    .CHIME_REPS(CHIME_REPS), .HORN_HALF(HORN_HALF), .TICK_HALF(TICK_HALF),
    .TOCK_HALF(TOCK_HALF), .CHIME_HALF(CHIME_HALF)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .horn_req_i(horn_req_i), .click_evt_i(click_evt_i),
    .click_hi_i(click_hi_i), .chime_evt_i(chime_evt_i), .melody_req_i(melody_req_i),
    .melody_half_i(melody_half_i), .engine_req_i(engine_req_i), .engine_half_i(engine_half_i),
    .grant_o(grant_o), .tone_half_o(tone_half_o), .tone_duty_o(tone_duty_o),
    .tone_restart_o(tone_restart_o), .click_drop_o(click_drop_o),
    .chime_busy_o(chime_busy_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // scoreboard state
  logic [29:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cnt_busy, cnt_rs, cnt_drop, cnt_click;

  // reference model state
  int  m_owner, m_click_left;
  bit  m_click_pend, m_click_hi, m_tone_hi;
  bit  seg_on[$];
  int  seg_left[$];
  logic [4:0]  m_grant;
  logic [19:0] m_half;
  logic [1:0]  m_duty;
  logic        m_restart, m_drop, m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = OWN_IDLE; m_click_left = 0;
    m_click_pend = 0; m_click_hi = 0; m_tone_hi = 0;
    seg_on.delete(); seg_left.delete();
    exp_q.delete();
  endtask

  // One clock edge of the arbiter, described as owners, a remaining click
  // length and a queue of pending chime beep/gap segments.
  task automatic model_step();
    int prev;
    bit popped, reload, busy_before;
    prev = m_owner; popped = 0; reload = 0;
    busy_before = (seg_left.size() != 0);
    m_drop = click_evt_i && m_click_pend;
    if (click_evt_i) begin m_click_pend = 1; m_click_hi = click_hi_i; end
    if (chime_evt_i && !busy_before)
      for (int r = 0; r < CHIME_REPS; r++) begin
        seg_on.push_back(1); seg_left.push_back(CHIME_ON);
        seg_on.push_back(0); seg_left.push_back(CHIME_OFF);
      end
    if (prev == OWN_CHIME) begin
      seg_left[0] = seg_left[0] - 1;
      if (seg_left[0] == 0) begin
        void'(seg_on.pop_front()); void'(seg_left.pop_front()); popped = 1;
      end
    end
    if (prev == OWN_CLICK) m_click_left--;
    if (horn_req_i) begin m_owner = OWN_HORN; m_click_left = 0; end
    else if (prev == OWN_CLICK && m_click_left > 0) m_owner = OWN_CLICK;
    else if (m_click_pend) begin
      m_owner = OWN_CLICK; m_click_left = CLICK_CYC; m_click_pend = 0;
      m_tone_hi = m_click_hi; reload = 1;
    end
    else if (seg_left.size() != 0) m_owner = OWN_CHIME;
    else if (melody_req_i) m_owner = OWN_MELODY;
    else if (engine_req_i) m_owner = OWN_ENGINE;
    else m_owner = OWN_IDLE;
    m_restart = (m_owner != prev) || reload || (m_owner == OWN_CHIME && prev == OWN_CHIME && popped);
    m_busy = (seg_left.size() != 0);
    case (m_owner)
      OWN_HORN:   begin m_grant = 5'b10000; m_half = 20'(HORN_HALF); m_duty = 2'd1; end
      OWN_CLICK:  begin m_grant = 5'b01000; m_half = m_tone_hi ? 20'(TICK_HALF) : 20'(TOCK_HALF); m_duty = 2'd2; end
      OWN_CHIME:  begin m_grant = 5'b00100; m_half = seg_on[0] ? 20'(CHIME_HALF) : 20'd0; m_duty = 2'd1; end
      OWN_MELODY: begin m_grant = 5'b00010; m_half = melody_half_i; m_duty = 2'd2; end
      OWN_ENGINE: begin m_grant = 5'b00001; m_half = engine_half_i; m_duty = 2'd3; end
      default:    begin m_grant = 5'b00000; m_half = 20'd0; m_duty = 2'd0; end
    endcase
  endtask

  // driver: advance one clock, predict, then check #1 after the edge
  task automatic tick();
    logic [29:0] e;
    @(posedge clk_i);
    model_step();
    exp_q.push_back({m_grant, m_half, m_duty, m_restart, m_drop, m_busy});
    #1;
    e = exp_q.pop_front();
    check("grant",   32'(grant_o),        32'(e[29:25]));
    check("half",    32'(tone_half_o),    32'(e[24:5]));
    check("duty",    32'(tone_duty_o),    32'(e[4:3]));
    check("restart", 32'(tone_restart_o), 32'(e[2]));
    check("drop",    32'(click_drop_o),   32'(e[1]));
    check("busy",    32'(chime_busy_o),   32'(e[0]));
    if (chime_busy_o) cnt_busy++;
    if (chime_busy_o && tone_restart_o) cnt_rs++;
    if (click_drop_o) cnt_drop++;
    if (grant_o == 5'b01000) cnt_click++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    cnt_busy = 0; cnt_rs = 0; cnt_drop = 0; cnt_click = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"},   32'(grant_o), 32'd0);
    check({tag, "_half"},    32'(tone_half_o), 32'd0);
    check({tag, "_duty"},    32'(tone_duty_o), 32'd0);
    check({tag, "_restart"}, 32'(tone_restart_o), 32'd0);
    check({tag, "_drop"},    32'(click_drop_o), 32'd0);
    check({tag, "_busy"},    32'(chime_busy_o), 32'd0);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      check_zero("rst");
    end
  endtask

  task automatic pulse_click(input logic hi);
    click_evt_i = 1'b1; click_hi_i = hi;
    tick();
    click_evt_i = 1'b0;
  endtask

  task automatic pulse_chime();
    chime_evt_i = 1'b1;
    tick();
    chime_evt_i = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_counts();
    #2;
    check_zero("por");
    hold_reset(3);
    rst_ni = 1'b1;

    // engine grant
    engine_req_i = 1'b1; engine_half_i = 20'd5000;
    tick();
    check("t1_grant", 32'(grant_o), 32'b00001);
    check("t1_half",  32'(tone_half_o), 32'd5000);
    check("t1_restart", 32'(tone_restart_o), 32'd1);
    ticks(5);

    // tick click over engine
    clear_counts();
    pulse_click(1'b1);
    check("t2_half", 32'(tone_half_o), 32'(TICK_HALF));
    ticks(14);
    check("t2_click_len", 32'(cnt_click), 32'd10);
    check("t2_back_engine", 32'(grant_o), 32'b00001);

    // lone chime
    engine_req_i = 1'b0;
    ticks(2);
    clear_counts();
    pulse_chime();
    ticks(70);
    check("t3_busy_len", 32'(cnt_busy), 32'd60);
    check("t3_restarts", 32'(cnt_rs), 32'd4);

    // horn preempts chime at ON cycle 8 for 15 cycles
    clear_counts();
    pulse_chime();
    ticks(7);
    horn_req_i = 1'b1;
    ticks(15);
    check("t4_horn", 32'(grant_o), 32'b10000);
    horn_req_i = 1'b0;
    ticks(80);
    check("t4_busy_len", 32'(cnt_busy), 32'd75);

    // two clicks under the horn
    clear_counts();
    horn_req_i = 1'b1;
    tick();
    pulse_click(1'b0);
    ticks(2);
    pulse_click(1'b1);
    ticks(3);
    horn_req_i = 1'b0;
    tick();
    check("t5_click_half", 32'(tone_half_o), 32'(TICK_HALF));
    ticks(15);
    check("t5_drops", 32'(cnt_drop), 32'd1);
    check("t5_click_len", 32'(cnt_click), 32'd10);

    // async reset in the middle of a click
    engine_req_i = 1'b1;
    ticks(2);
    pulse_click(1'b0);
    ticks(3);
    #2 rst_ni = 1'b0;
    #1 check_zero("t6_async");
    model_reset();
    hold_reset(2);
    rst_ni = 1'b1;
    tick();
    check("t6_engine", 32'(grant_o), 32'b00001);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if (horn_req_i) begin if ($urandom_range(0, 9) == 0) horn_req_i = 1'b0; end
      else if ($urandom_range(0, 199) == 0) horn_req_i = 1'b1;
      click_evt_i = ($urandom_range(0, 39) == 0);
      click_hi_i  = 1'($urandom_range(0, 1));
      chime_evt_i = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 49) == 0) melody_req_i = ~melody_req_i;
      if ($urandom_range(0, 49) == 0) engine_req_i = ~engine_req_i;
      if ($urandom_range(0, 9) == 0) melody_half_i = 20'($urandom_range(0, 1000));
      if ($urandom_range(0, 9) == 0) engine_half_i = 20'($urandom_range(1000, 90000));
      tick();
    end
    click_evt_i = 1'b0; chime_evt_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
